rtc_bus_ctrl: RTL

Transaction engine between the timekeeping logic in `Sistema` and the external RTC chip's multiplexed address/data bus. It accepts one read or write request at a time and sequences the active-low `C_S`, `R_D` and `W_R` strobes and the `A_D` select through an address cycle followed by a data cycle. It drives `AD_OUT` and `ad_oe` for the top-level tri-state pad, and captures `AD_IN` on reads. Upstream request logic, VGA register readback and button/switch editing all reach the chip only through this block.

---
 rtl/rtc_pkg.sv | 31 +++
 rtl/rtc_phase_timer.sv | 28 ++
 rtl/rtc_bus_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC chip bus engine: widths, register map, FSM states.
// Optional feature macro used by this slice: RTC_BUS_BCD_CHECK_EN.
package rtc_pkg;

   localparam int RTC_ADDR_W = 8;
   localparam int RTC_DATA_W = 8;

   localparam logic [RTC_ADDR_W-1:0] RTC_REG_SEC   = 8'h21;
   localparam logic [RTC_ADDR_W-1:0] RTC_REG_MIN   = 8'h22;
   localparam logic [RTC_ADDR_W-1:0] RTC_REG_HOUR  = 8'h23;
   localparam logic [RTC_ADDR_W-1:0] RTC_REG_DATE  = 8'h24;
   localparam logic [RTC_ADDR_W-1:0] RTC_REG_MONTH = 8'h25;
   localparam logic [RTC_ADDR_W-1:0] RTC_REG_YEAR  = 8'h26;
   localparam logic [RTC_ADDR_W-1:0] RTC_REG_CMD   = 8'hF0;

   typedef enum logic [2:0] {
      IDLE,
      A_SET,
      A_STB,
      A_HLD,
      GAP,
      D_STB,
      D_HLD,
      DONE
   } rtc_state_t;

   function automatic logic is_bcd(input logic [RTC_DATA_W-1:0] b);
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase down-counter: reloads to PHASE_CYC-1 on load, flags expired when it reaches zero.
module rtc_phase_timer #(
   parameter int PHASE_CYC = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expired
);

   localparam int CW = $clog2(PHASE_CYC + 1);
   localparam logic [CW-1:0] RELOAD = CW'(PHASE_CYC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= RELOAD;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Single-transaction engine for the RTC multiplexed address/data bus (address then data cycle).
// Optional RTC_BUS_BCD_CHECK_EN adds rd_err, flagging non-BCD bytes on read completion.
module rtc_bus_ctrl
   import rtc_pkg::*;
#(
   parameter int PHASE_CYC = 10
) (
   input  logic                  CLOCK_NEXYS,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  rnw,
   input  logic [RTC_ADDR_W-1:0] addr,
   input  logic [RTC_DATA_W-1:0] wdata,
   output logic [RTC_DATA_W-1:0] rdata,
   output logic                  busy,
   output logic                  done,
   input  logic [RTC_DATA_W-1:0] AD_IN,
   output logic [RTC_DATA_W-1:0] AD_OUT,
   output logic                  ad_oe,
   output logic                  A_D,
   output logic                  C_S,
   output logic                  R_D,
   output logic                  W_R
`ifdef RTC_BUS_BCD_CHECK_EN
   ,
   output logic                  rd_err
`endif
);

   rtc_state_t state, state_n;

   logic                  rnw_q, rnw_n;
   logic [RTC_ADDR_W-1:0] addr_q, addr_n;
   logic [RTC_DATA_W-1:0] wdata_q, wdata_n;

   logic                  load, expired, capture;
   logic [RTC_DATA_W-1:0] ad_out_n;
   logic                  ad_oe_n, a_d_n, c_s_n, r_d_n, w_r_n, busy_n, done_n;

   rtc_phase_timer #(
      .PHASE_CYC (PHASE_CYC)
   ) u_timer (
      .clk     (CLOCK_NEXYS),
      .rst     (reset),
      .load    (load),
      .expired (expired)
   );

   always_comb begin
      state_n = state;
      rnw_n   = rnw_q;
      addr_n  = addr_q;
      wdata_n = wdata_q;
      unique case (state)
         IDLE: if (req) begin
            state_n = A_SET;
            rnw_n   = rnw;
            addr_n  = addr;
            wdata_n = wdata;
         end
         A_SET:   if (expired) state_n = A_STB;
         A_STB:   if (expired) state_n = A_HLD;
         A_HLD:   if (expired) state_n = GAP;
         GAP:     if (expired) state_n = D_STB;
         D_STB:   if (expired) state_n = D_HLD;
         D_HLD:   if (expired) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      load    = (state_n != state);
      capture = (state == D_STB) && expired && rnw_q;
   end

   // Pad outputs are decoded from the next state and registered, so nothing reaches the
   // pads combinationally. Write data is put on the bus during GAP so that ad_oe never
   // changes in the same cycle W_R falls.
   always_comb begin
      ad_out_n = AD_OUT;
      ad_oe_n  = 1'b0;
      a_d_n    = 1'b1;
      c_s_n    = 1'b1;
      r_d_n    = 1'b1;
      w_r_n    = 1'b1;
      busy_n   = !((state_n == IDLE) || (state_n == DONE));
      done_n   = (state_n == DONE);
      unique case (state_n)
         A_SET, A_HLD: begin
            a_d_n    = 1'b0;
            ad_out_n = addr_n;
            ad_oe_n  = 1'b1;
         end
         A_STB: begin
            a_d_n    = 1'b0;
            ad_out_n = addr_n;
            ad_oe_n  = 1'b1;
            c_s_n    = 1'b0;
            w_r_n    = 1'b0;
         end
         GAP, D_HLD: if (!rnw_n) begin
            ad_out_n = wdata_n;
            ad_oe_n  = 1'b1;
         end
         D_STB: begin
            c_s_n = 1'b0;
            if (rnw_n) begin
               r_d_n = 1'b0;
            end else begin
               w_r_n    = 1'b0;
               ad_out_n = wdata_n;
               ad_oe_n  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_NEXYS or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         rnw_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata   <= '0;
         AD_OUT  <= '0;
         ad_oe   <= 1'b0;
         A_D     <= 1'b1;
         C_S     <= 1'b1;
         R_D     <= 1'b1;
         W_R     <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         rnw_q   <= rnw_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
         AD_OUT  <= ad_out_n;
         ad_oe   <= ad_oe_n;
         A_D     <= a_d_n;
         C_S     <= c_s_n;
         R_D     <= r_d_n;
         W_R     <= w_r_n;
         busy    <= busy_n;
         done    <= done_n;
         if (capture) rdata <= AD_IN;
      end
   end

`ifdef RTC_BUS_BCD_CHECK_EN
   always_ff @(posedge CLOCK_NEXYS or posedge reset) begin
      if (reset) begin
         rd_err <= 1'b0;
      end else if (capture) begin
         rd_err <= !is_bcd(AD_IN);
      end
   end
`endif

endmodule
